// File: rtl/adder_if.sv
// Stream bundle for the registered adder: operand side (a, b, in_valid/in_ready)
// and result side (y, ovf, zero, out_valid/out_ready).
interface adder_if #(
  parameter int WIDTH_IN  = 8,
  parameter int WIDTH_OUT = 9
);
  logic [WIDTH_IN-1:0]  a;
  logic [WIDTH_IN-1:0]  b;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH_OUT-1:0] y;
  logic                 out_valid;
  logic                 out_ready;
  logic                 ovf;
  logic                 zero;

  // Producer of operands and consumer of results
  modport master (
    output a, b, in_valid, out_ready,
    input  in_ready, y, out_valid, ovf, zero
  );

  // The adder itself
  modport slave (
    input  a, b, in_valid, out_ready,
    output in_ready, y, out_valid, ovf, zero
  );
endinterface

// File: rtl/adder_unit.sv
// Registered two-operand adder with one output-register stage on a
// valid/ready stream. Produces the low WIDTH_OUT bits of the exact sum plus
// overflow and zero flags, all registered together.
module adder_unit #(
  parameter int WIDTH_IN  = 8,
  parameter int WIDTH_OUT = 9,
  parameter bit SIGNED    = 1'b0
) (
  input  logic   clk,
  input  logic   reset,
  adder_if.slave bus
);

  // Width at which the sum is exact; also large enough to carry the
  // extension when the output is wider than WIDTH_IN+1.
  localparam int SUM_W = ((WIDTH_IN + 1) > WIDTH_OUT) ? (WIDTH_IN + 1) : WIDTH_OUT;

  genvar gi;

  logic                 ext_a_bit;
  logic                 ext_b_bit;
  logic [SUM_W-1:0]     a_ext;
  logic [SUM_W-1:0]     b_ext;
  logic [SUM_W-1:0]     sum_full;
  logic                 sum_ovf;

  logic                 in_ready_int;
  logic                 in_xfer;
  logic                 out_xfer;

  logic [WIDTH_OUT-1:0] y_q, y_d;
  logic                 ovf_q, ovf_d;
  logic                 zero_q, zero_d;
  logic                 out_valid_q, out_valid_d;

  // Operand extension: sign bit replicated in signed mode, zeros otherwise
  assign ext_a_bit = SIGNED ? bus.a[WIDTH_IN-1] : 1'b0;
  assign ext_b_bit = SIGNED ? bus.b[WIDTH_IN-1] : 1'b0;
  assign a_ext     = {{(SUM_W - WIDTH_IN){ext_a_bit}}, bus.a};
  assign b_ext     = {{(SUM_W - WIDTH_IN){ext_b_bit}}, bus.b};
  assign sum_full  = a_ext + b_ext;

  // Overflow only exists when the output drops bits of the exact sum
  generate
    if (WIDTH_OUT >= WIDTH_IN + 1) begin : g_no_ovf
      assign sum_ovf = 1'b0;
    end else if (SIGNED) begin : g_signed_ovf
      // Fits the signed output range iff every dropped bit equals the new sign bit
      logic [SUM_W-WIDTH_OUT-1:0] sign_diff;
      for (gi = WIDTH_OUT; gi < SUM_W; gi++) begin : g_sign_cmp
        assign sign_diff[gi-WIDTH_OUT] = sum_full[gi] ^ sum_full[WIDTH_OUT-1];
      end
      assign sum_ovf = |sign_diff;
    end else begin : g_unsigned_ovf
      assign sum_ovf = |sum_full[SUM_W-1:WIDTH_OUT];
    end
  endgenerate

  // Stage can take new operands when empty or being drained this cycle
  assign in_ready_int = !out_valid_q || bus.out_ready;
  assign in_xfer      = bus.in_valid && in_ready_int;
  assign out_xfer     = out_valid_q && bus.out_ready;

  // Next-state for the result register: load beats drain, otherwise hold
  always_comb begin
    y_d         = y_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    if (in_xfer) begin
      y_d         = sum_full[WIDTH_OUT-1:0];
      ovf_d       = sum_ovf;
      zero_d      = (sum_full[WIDTH_OUT-1:0] == '0);
      out_valid_d = 1'b1;
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
  end

  // Result register with synchronous active-low reset taking priority
  always_ff @(posedge clk) begin
    if (!reset) begin
      y_q         <= '0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      y_q         <= y_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.y         = y_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_adder_unit.sv
// Bench for adder_unit: four configurations driven by one shared stream
// (8->9 unsigned, 8->8 unsigned, 8->8 signed, 8->10 signed), checked against
// constant vectors and an integer-arithmetic reference model.
module tb_adder_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] a_drv, b_drv;
  logic       in_valid_drv, out_ready_drv;

  int checks = 0;
  int errors = 0;

  adder_if #(.WIDTH_IN(8), .WIDTH_OUT(9))  if0 ();
  adder_if #(.WIDTH_IN(8), .WIDTH_OUT(8))  if1 ();
  adder_if #(.WIDTH_IN(8), .WIDTH_OUT(8))  if2 ();
  adder_if #(.WIDTH_IN(8), .WIDTH_OUT(10)) if3 ();

  adder_unit #(.WIDTH_IN(8), .WIDTH_OUT(9),  .SIGNED(1'b0)) u0 (.clk(clk), .reset(reset), .bus(if0.slave));
  adder_unit #(.WIDTH_IN(8), .WIDTH_OUT(8),  .SIGNED(1'b0)) u1 (.clk(clk), .reset(reset), .bus(if1.slave));
  adder_unit #(.WIDTH_IN(8), .WIDTH_OUT(8),  .SIGNED(1'b1)) u2 (.clk(clk), .reset(reset), .bus(if2.slave));
  adder_unit #(.WIDTH_IN(8), .WIDTH_OUT(10), .SIGNED(1'b1)) u3 (.clk(clk), .reset(reset), .bus(if3.slave));

  assign if0.a = a_drv; assign if0.b = b_drv; assign if0.in_valid = in_valid_drv; assign if0.out_ready = out_ready_drv;
  assign if1.a = a_drv; assign if1.b = b_drv; assign if1.in_valid = in_valid_drv; assign if1.out_ready = out_ready_drv;
  assign if2.a = a_drv; assign if2.b = b_drv; assign if2.in_valid = in_valid_drv; assign if2.out_ready = out_ready_drv;
  assign if3.a = a_drv; assign if3.b = b_drv; assign if3.in_valid = in_valid_drv; assign if3.out_ready = out_ready_drv;

  logic [15:0] dut_y  [4];
  logic        dut_ovf[4];
  logic        dut_zero[4];
  logic        dut_ov [4];
  logic        dut_ir [4];

  assign dut_y[0] = 16'(if0.y); assign dut_ovf[0] = if0.ovf; assign dut_zero[0] = if0.zero; assign dut_ov[0] = if0.out_valid; assign dut_ir[0] = if0.in_ready;
  assign dut_y[1] = 16'(if1.y); assign dut_ovf[1] = if1.ovf; assign dut_zero[1] = if1.zero; assign dut_ov[1] = if1.out_valid; assign dut_ir[1] = if1.in_ready;
  assign dut_y[2] = 16'(if2.y); assign dut_ovf[2] = if2.ovf; assign dut_zero[2] = if2.zero; assign dut_ov[2] = if2.out_valid; assign dut_ir[2] = if2.in_ready;
  assign dut_y[3] = 16'(if3.y); assign dut_ovf[3] = if3.ovf; assign dut_zero[3] = if3.zero; assign dut_ov[3] = if3.out_valid; assign dut_ir[3] = if3.in_ready;

  // Reference model state: one shared valid flag, per-configuration result
  logic        m_valid = 1'b0;
  logic [15:0] m_y   [4];
  logic        m_ovf [4];
  logic        m_zero[4];
  logic        exp_ir;
  logic        obs_ir[4];

  // Directed vectors: packed element k belongs to DUT k
  logic [7:0]       tv_a [5] = '{8'h03, 8'hFF, 8'h00, 8'h7F, 8'hFF};
  logic [7:0]       tv_b [5] = '{8'h05, 8'h01, 8'h00, 8'h01, 8'hFF};
  logic [3:0][15:0] tv_y [5] = '{
    {16'h008, 16'h008, 16'h008, 16'h008},
    {16'h000, 16'h000, 16'h000, 16'h100},
    {16'h000, 16'h000, 16'h000, 16'h000},
    {16'h080, 16'h080, 16'h080, 16'h080},
    {16'h3FE, 16'h0FE, 16'h0FE, 16'h1FE}
  };
  logic [3:0]       tv_ovf [5] = '{4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0010};

  function automatic int cfg_wo(input int k);
    case (k)
      0:       return 9;
      1:       return 8;
      2:       return 8;
      default: return 10;
    endcase
  endfunction

  function automatic bit cfg_signed(input int k);
    return (k >= 2);
  endfunction

  // Exact integer sum, truncated and range-checked
  function automatic void calc(input int k, input logic [7:0] ai, input logic [7:0] bi,
                               output logic [15:0] yo, output logic ovo);
    int wo;
    int ea;
    int eb;
    int s;
    wo = cfg_wo(k);
    ea = cfg_signed(k) ? int'($signed(ai)) : int'(ai);
    eb = cfg_signed(k) ? int'($signed(bi)) : int'(bi);
    s  = ea + eb;
    yo = 16'(s & ((1 << wo) - 1));
    if (cfg_signed(k))
      ovo = (s > ((1 << (wo - 1)) - 1)) || (s < -(1 << (wo - 1)));
    else
      ovo = (s >= (1 << wo));
  endfunction

  // Drive one cycle, sample in_ready before the edge, advance the model
  task automatic cycle(input logic rn, input logic [7:0] ai, input logic [7:0] bi,
                       input logic vi, input logic ri);
    logic [15:0] yy;
    logic        oo;
    @(negedge clk);
    reset = rn; a_drv = ai; b_drv = bi; in_valid_drv = vi; out_ready_drv = ri;
    #1;
    exp_ir = !m_valid || ri;
    for (int k = 0; k < 4; k++) obs_ir[k] = dut_ir[k];
    @(posedge clk);
    if (!rn) begin
      m_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
        m_y[k] = 16'h0; m_ovf[k] = 1'b0; m_zero[k] = 1'b1;
      end
    end else if (vi && exp_ir) begin
      m_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
        calc(k, ai, bi, yy, oo);
        m_y[k] = yy; m_ovf[k] = oo; m_zero[k] = (yy == 16'h0);
      end
    end else if (m_valid && ri) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(1'b0, 8'h12, 8'h34, 1'b1, 1'b0);
    cycle(1'b0, 8'h56, 8'h78, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (dut_ov[k] !== 1'b0 || dut_y[k] !== 16'h0 || dut_ovf[k] !== 1'b0 || dut_zero[k] !== 1'b1) begin
        errors++;
        $display("FAIL reset dut%0d: got v=%b y=%h o=%b z=%b, expected v=0 y=0000 o=0 z=1",
                 k, dut_ov[k], dut_y[k], dut_ovf[k], dut_zero[k]);
      end
      checks++;
      if (obs_ir[k] !== 1'b1) begin
        errors++;
        $display("FAIL reset_in_ready dut%0d: got %b, expected 1", k, obs_ir[k]);
      end
    end
    $display("reset: held two edges with in_valid=1");
  endtask

  task automatic test_vectors();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, tv_a[i], tv_b[i], 1'b1, 1'b1);
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (dut_ov[k] !== 1'b1 || dut_y[k] !== tv_y[i][k] || dut_ovf[k] !== tv_ovf[i][k] ||
            dut_zero[k] !== (tv_y[i][k] == 16'h0)) begin
          errors++;
          $display("FAIL vector%0d dut%0d: got v=%b y=%h o=%b z=%b, expected v=1 y=%h o=%b z=%b",
                   i, k, dut_ov[k], dut_y[k], dut_ovf[k], dut_zero[k],
                   tv_y[i][k], tv_ovf[i][k], (tv_y[i][k] == 16'h0));
        end
      end
      $display("vector: a=%h b=%h -> y0=%h y1=%h y2=%h y3=%h", tv_a[i], tv_b[i],
               dut_y[0], dut_y[1], dut_y[2], dut_y[3]);
    end
    cycle(1'b1, 8'h00, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    cycle(1'b1, 8'h10, 8'h20, 1'b1, 1'b0);
    checks++;
    if (dut_y[0] !== 16'h030 || dut_ov[0] !== 1'b1 || dut_ir[0] !== 1'b0) begin
      errors++;
      $display("FAIL bp_load: got y=%h v=%b in_ready=%b, expected y=0030 v=1 in_ready=0",
               dut_y[0], dut_ov[0], dut_ir[0]);
    end
    $display("bp: load a=10 b=20 out_ready=0 -> y=%h", dut_y[0]);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 8'($urandom), 8'($urandom), 1'b1, 1'b0);
      checks++;
      if (dut_y[0] !== 16'h030 || dut_ov[0] !== 1'b1 || obs_ir[0] !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: got y=%h v=%b in_ready=%b, expected y=0030 v=1 in_ready=0",
                 i, dut_y[0], dut_ov[0], obs_ir[0]);
      end
      $display("bp: stall cycle %0d offered a=%h b=%h -> y=%h", i, a_drv, b_drv, dut_y[0]);
    end
    cycle(1'b1, 8'h01, 8'h01, 1'b1, 1'b1);
    checks++;
    if (obs_ir[0] !== 1'b1 || dut_y[0] !== 16'h002 || dut_ov[0] !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got in_ready=%b y=%h v=%b, expected in_ready=1 y=0002 v=1",
               obs_ir[0], dut_y[0], dut_ov[0]);
    end
    $display("bp: release with a=01 b=01 -> y=%h", dut_y[0]);
    cycle(1'b1, 8'h00, 8'h00, 1'b0, 1'b1);
    checks++;
    if (dut_ov[0] !== 1'b0 || dut_y[0] !== 16'h002) begin
      errors++;
      $display("FAIL bp_drain: got v=%b y=%h, expected v=0 y=0002", dut_ov[0], dut_y[0]);
    end
    $display("bp: drain -> v=%b y=%h", dut_ov[0], dut_y[0]);
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 8'h40, 8'h02, 1'b1, 1'b0);
    cycle(1'b0, 8'h11, 8'h22, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (dut_ov[k] !== 1'b0 || dut_y[k] !== 16'h0 || dut_zero[k] !== 1'b1 || dut_ovf[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid dut%0d: got v=%b y=%h o=%b z=%b, expected v=0 y=0000 o=0 z=1",
                 k, dut_ov[k], dut_y[k], dut_ovf[k], dut_zero[k]);
      end
    end
    $display("reset_mid: pending result discarded -> v=%b y=%h", dut_ov[0], dut_y[0]);
    cycle(1'b1, 8'h02, 8'h03, 1'b1, 1'b1);
    checks++;
    if (dut_ov[0] !== 1'b1 || dut_y[0] !== 16'h005) begin
      errors++;
      $display("FAIL reset_release: got v=%b y=%h, expected v=1 y=0005", dut_ov[0], dut_y[0]);
    end
    $display("reset_mid: first edge after release a=02 b=03 -> y=%h", dut_y[0]);
  endtask

  task automatic test_random();
    logic       rn, vi, ri;
    logic [7:0] ai, bi;
    for (int n = 0; n < 1500; n++) begin
      rn = ($urandom_range(0, 63) != 0);
      vi = ($urandom_range(0, 3) != 0);
      ri = ($urandom_range(0, 2) != 0);
      ai = 8'($urandom);
      bi = 8'($urandom);
      cycle(rn, ai, bi, vi, ri);
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (obs_ir[k] !== exp_ir) begin
          errors++;
          $display("FAIL rand_in_ready n=%0d dut%0d: got %b, expected %b", n, k, obs_ir[k], exp_ir);
        end
        checks++;
        if (dut_ov[k] !== m_valid || dut_y[k] !== m_y[k] || dut_ovf[k] !== m_ovf[k] || dut_zero[k] !== m_zero[k]) begin
          errors++;
          $display("FAIL rand n=%0d dut%0d: got v=%b y=%h o=%b z=%b, expected v=%b y=%h o=%b z=%b",
                   n, k, dut_ov[k], dut_y[k], dut_ovf[k], dut_zero[k], m_valid, m_y[k], m_ovf[k], m_zero[k]);
        end
      end
      $display("rand %0d: rst_n=%b a=%h b=%h iv=%b or=%b -> v=%b y0=%h y2=%h o2=%b",
               n, rn, ai, bi, vi, ri, dut_ov[0], dut_y[0], dut_y[2], dut_ovf[2]);
    end
  endtask

  task automatic test_sweep();
    int row_err;
    cycle(1'b1, 8'h00, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 256; i++) begin
      row_err = errors;
      for (int j = 0; j < 256; j++) begin
        cycle(1'b1, 8'(i), 8'(j), 1'b1, 1'b1);
        checks++;
        if (dut_ov[0] !== 1'b1 || dut_y[0] !== 16'(i + j) || dut_ovf[0] !== 1'b0 ||
            dut_zero[0] !== ((i + j) == 0)) begin
          errors++;
          $display("FAIL sweep a=%h b=%h: got v=%b y=%h o=%b z=%b, expected v=1 y=%h o=0 z=%b",
                   i, j, dut_ov[0], dut_y[0], dut_ovf[0], dut_zero[0], 16'(i + j), ((i + j) == 0));
        end
      end
      $display("sweep: a=%h row of 256 operands, %0d errors in row", i, errors - row_err);
    end
  endtask

  initial begin
    reset = 1'b0; a_drv = 8'h0; b_drv = 8'h0; in_valid_drv = 1'b0; out_ready_drv = 1'b0;
    for (int k = 0; k < 4; k++) begin
      m_y[k] = 16'h0; m_ovf[k] = 1'b0; m_zero[k] = 1'b1;
    end
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_unit.md
# adder_unit

Registered, parameterised two-operand adder with a valid/ready stream interface. It adds two `WIDTH_IN`-bit operands into a `WIDTH_OUT`-bit sum. It flags overflow when the sum does not fit the output width and flags a zero result. It is the basic arithmetic element of the datapath and is exercised by the team's two-input/one-output vector bench.

## Interface
Parameters:
- `WIDTH_IN`, default 8: width of each operand.
- `WIDTH_OUT`, default 9: width of the sum. The default `WIDTH_IN+1` holds every result with no loss. Legal range is 1 to 2*`WIDTH_IN`.
- `SIGNED`, default 0: selects how operands are treated.
  - 0: operands are unsigned and zero-extended.
  - 1: operands are two's complement and sign-extended.

Ports:
- `clk` input, 1 bit: single clock. All state changes on the rising edge.
- `reset` input, 1 bit: reset is synchronous and active-low. It is asserted when 0 and sampled on the rising edge of `clk`.
- `a` input, `WIDTH_IN` bits: operand A.
- `b` input, `WIDTH_IN` bits: operand B.
- `in_valid` input, 1 bit: the upstream side presents valid `a` and `b`.
- `in_ready` output, 1 bit: the block can accept operands this cycle.
- `y` output, `WIDTH_OUT` bits: registered sum.
- `out_valid` output, 1 bit: `y`, `ovf` and `zero` hold a valid result.
- `out_ready` input, 1 bit: the downstream side accepts the result this cycle.
- `ovf` output, 1 bit: the exact sum does not fit in `WIDTH_OUT` bits.
- `zero` output, 1 bit: `y` is all zeros.

## Operation
Arithmetic:
- The exact sum is computed at width `max(WIDTH_IN+1, WIDTH_OUT)`.
- Operands are extended according to `SIGNED` before the addition.
- `y` is the low `WIDTH_OUT` bits of the exact sum. When `WIDTH_OUT` is larger than `WIDTH_IN+1`, the value is extended (zero or sign).
- `ovf` when `SIGNED`=0: 1 when any discarded upper bit of the exact sum is 1.
- `ovf` when `SIGNED`=1: 1 when the exact sum is outside the signed `WIDTH_OUT` range.
- `ovf` is always 0 when `WIDTH_OUT` is at least `WIDTH_IN+1`.
- `zero` = (`y` == 0), registered together with `y`.

Handshake:
- The block is a single output-register stage.
- An input transfer happens when `in_valid` and `in_ready` are both 1.
- An output transfer happens when `out_valid` and `out_ready` are both 1.
- `in_ready` = !`out_valid` || `out_ready`. This is combinational, so a full stage accepts new operands in the same cycle its result is drained.
- On an input transfer, `y`, `ovf` and `zero` load the new result and `out_valid` is set to 1.
- On an output transfer with no input transfer, `out_valid` is cleared to 0. `y` holds its last value.
- While `out_valid`=1 and `out_ready`=0 (stalled), `y`, `ovf`, `zero` and `out_valid` hold. Operand inputs are ignored.
- `a` and `b` are don't-care when `in_valid`=0.

Reset (when `reset`=0 at a rising edge):
- `y`=0, `ovf`=0, `zero`=1, `out_valid`=0.
- Any pending result is discarded.
- Reset has priority over any transfer in the same cycle.
- `in_ready` reads 1 while `out_valid`=0, including during reset.

## Timing
- Latency is 1 cycle. Operands accepted at edge N appear on `y` with `out_valid`=1 after edge N.
- Throughput is 1 result per cycle while `out_ready` is held at 1.
- There is no combinational path from `a`/`b` to any output.
- The only combinational path is `out_ready` to `in_ready`.
- When a drain and a load occur in the same edge, the new result replaces the old one. `out_valid` stays 1 and no bubble is inserted.
- Deasserting `reset` mid-stream: the first transfer can occur at the first edge sampled with `reset`=1.

## Test plan
- Defaults (8→9, unsigned), `out_ready`=1: a=0x03, b=0x05 -> y=0x008, ovf=0, zero=0 one cycle later.
- Defaults: a=0xFF, b=0x01 -> y=0x100, ovf=0. Then a=0x00, b=0x00 -> y=0x000, zero=1.
- `WIDTH_OUT`=8: a=0xFF, b=0x01 -> y=0x00, ovf=1, zero=1.
- `SIGNED`=1, `WIDTH_OUT`=8: a=0x7F, b=0x01 -> y=0x80, ovf=1. Also a=0xFF, b=0xFF -> y=0xFE, ovf=0.
- Backpressure sequence:
  - Load a=0x10, b=0x20 with `out_ready`=0 -> y=0x030, `out_valid`=1, `in_ready`=0.
  - y holds 3 cycles while new operands are offered.
  - Raise `out_ready` with a=0x01, b=0x01 -> next y=0x002 with no bubble.
- Reset mid-operation: result pending with `out_valid`=1, then `reset`=0 for one edge -> `out_valid`=0, y=0, zero=1.
- Vector sweep: every 256×256 unsigned pair checked against a+b at 9 bits, with zero mismatches.
